// File: rtl/mac_stream_sequencer.sv
// Operand-pair buffer that streams a dot product into the 4x4 pipelined MAC
// and captures the accumulated result once the pipeline has drained.
module mac_stream_sequencer #(
    parameter int DEPTH   = 4,
    parameter int MAC_LAT = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [3:0] wr_a,
    input  logic [3:0] wr_b,
    input  logic       start,
    output logic       full,
    output logic [2:0] count,
    output logic       busy,
    output logic       wr_err,
    output logic [3:0] mac_a,
    output logic [3:0] mac_b,
    output logic       mac_clr,
    input  logic [9:0] mac_acc,
    output logic [9:0] result,
    output logic       done
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        STREAM,
        DRAIN,
        CAPTURE
    } state_t;

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_t     state;
    state_t     state_n;
    logic [2:0] idx;
    logic [2:0] idx_n;
    logic [3:0] buf_a [DEPTH];
    logic [3:0] buf_b [DEPTH];
    logic       wr_ok;
    logic       start_ok;
    logic [3:0] a_n;
    logic [3:0] b_n;
    logic       clr_n;

    assign full  = (count == 3'(DEPTH));
    assign busy  = (state != IDLE);
    assign wr_ok = wr_en && (state == IDLE) && !full;
    // A write in the start cycle joins the run, so it can also make start valid.
    assign start_ok = start && (state == IDLE)
                      && ((count != 3'd0) || wr_ok);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            idx   <= 3'd0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
        end
    end

    always_comb begin
        state_n = state;
        idx_n   = idx;
        case (state)
            IDLE: begin
                if (start_ok)
                    state_n = CLEAR;
            end
            CLEAR: begin
                state_n = STREAM;
                idx_n   = 3'd0;
            end
            STREAM: begin
                if (idx == count - 3'd1) begin
                    state_n = DRAIN;
                    idx_n   = 3'd0;
                end else begin
                    idx_n = idx + 3'd1;
                end
            end
            DRAIN: begin
                if (idx == 3'(MAC_LAT - 2)) begin
                    state_n = CAPTURE;
                    idx_n   = 3'd0;
                end else begin
                    idx_n = idx + 3'd1;
                end
            end
            CAPTURE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // MAC drive is computed from the upcoming state so it is registered.
    always_comb begin
        a_n   = 4'd0;
        b_n   = 4'd0;
        clr_n = (state_n == CLEAR);
        if (state_n == STREAM) begin
            a_n = buf_a[idx_n[AW-1:0]];
            b_n = buf_b[idx_n[AW-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mac_a   <= 4'd0;
            mac_b   <= 4'd0;
            mac_clr <= 1'b0;
        end else begin
            mac_a   <= a_n;
            mac_b   <= b_n;
            mac_clr <= clr_n;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            buf_a[count[AW-1:0]] <= wr_a;
            buf_b[count[AW-1:0]] <= wr_b;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count  <= 3'd0;
            result <= 10'd0;
            done   <= 1'b0;
            wr_err <= 1'b0;
        end else begin
            done   <= (state == CAPTURE);
            wr_err <= wr_en && !wr_ok;
            if (wr_ok)
                count <= count + 3'd1;
            if (state == CAPTURE) begin
                result <= mac_acc;
                count  <= 3'd0;
            end
        end
    end

endmodule

// File: doc/mac_stream_sequencer.md
Name: mac_stream_sequencer

Overview:
- Initiator-side companion to the team's 4x4 pipelined MAC (operands a, b registered; product registered; 10-bit accumulator registered).
- Buffers up to DEPTH operand pairs from a write port. On start, it clears the MAC and streams the pairs into it one per cycle. It waits out the MAC pipeline, then captures the final dot product and pulses done.
- Sits between the host-side control logic and the MAC instance at the top level.

Parameters:
- DEPTH, 4, pair buffer capacity. The max sum DEPTH*225 must fit in 10 bits, so DEPTH <= 4.
- MAC_LAT, 3, cycles from a pair on mac_a/mac_b until its contribution is visible on mac_acc.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- wr_en  in  1  push wr_a/wr_b into buffer
- wr_a  in  4  operand a
- wr_b  in  4  operand b
- start  in  1  begin a dot-product run
- full  out  1  buffer holds DEPTH pairs
- count  out  3  pairs currently buffered
- busy  out  1  run in progress (state != IDLE)
- wr_err  out  1  one-cycle pulse when a write is dropped
- mac_a  out  4  operand a to MAC, registered
- mac_b  out  4  operand b to MAC, registered
- mac_clr  out  1  registered; high clears MAC (top level inverts it onto the MAC's active-low reset)
- mac_acc  in  10  MAC accumulator output
- result  out  10  captured dot product, held until next capture or reset
- done  out  1  one-cycle pulse, result valid

Behaviour:
- Reset (reset=1 at a rising edge):
  - state=IDLE; count=0.
  - full, busy, wr_err, done, mac_clr = 0.
  - mac_a = mac_b = 0; result = 0.
  - Buffer contents are don't-care.
  - Reset mid-run aborts the run with no done pulse. The top level must also reset the MAC.
- FSM states: IDLE, CLEAR, STREAM, DRAIN, CAPTURE.
- IDLE:
  - wr_en with count<DEPTH stores the pair at index count; count+1.
  - wr_en with count==DEPTH: pair dropped, wr_err pulses next cycle.
  - start with count>0 -> CLEAR. start with count==0 is ignored (no busy, no done).
  - wr_en and start in the same cycle: the write is accepted first and is included in the run.
- CLEAR (1 cycle):
  - mac_clr=1, mac_a=mac_b=0.
  - -> STREAM with index i=0.
- STREAM (count cycles):
  - In STREAM cycle i, mac_a/mac_b hold pair i and mac_clr=0.
  - After pair count-1 -> DRAIN.
- DRAIN (MAC_LAT-1 = 2 cycles):
  - mac_a=mac_b=0, so zero products enter the pipeline.
  - -> CAPTURE.
- CAPTURE (1 cycle):
  - result <= mac_acc; done=1 in the following cycle.
  - count <= 0 (buffer emptied) -> IDLE.
- Latency: if start is sampled in cycle 0, then CLEAR=1, STREAM=2..N+1, DRAIN=N+2..N+3, CAPTURE=N+4, done=N+5.
- During busy:
  - wr_en is dropped and wr_err pulses.
  - start is ignored.
  - mac_a/mac_b keep changing only as defined above.
- Arithmetic: products are unsigned 4x4. Accumulation is done by the MAC; this block never adds. With DEPTH<=4, no 10-bit wrap can occur.
- full = (count==DEPTH), combinational from count.
- busy is high from CLEAR through CAPTURE inclusive.
- done and wr_err are each exactly one cycle wide.

Test Plan:
- Reset, write (3,4),(5,6),(15,15),(15,15), start -> mac_clr high cycle 1; pairs on mac_a/mac_b cycles 2-5; done in cycle 9 with result=492; count=0 afterwards.
- Single pair (15,15), start -> done 6 cycles after start, result=225; a second run with (1,1) -> result=1, which proves the MAC was cleared.
- Write 5 pairs -> full=1 after the 4th; the 5th is dropped with a wr_err pulse; count stays 4.
- start with empty buffer -> busy stays 0; no done; no mac_clr.
- wr_en and start during STREAM -> write dropped with wr_err; start ignored; result unaffected (492 for the first vector).
- reset asserted in DRAIN -> next cycle IDLE with count=0, result=0, no done; a following run of (2,3) yields result=6.
